stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-stage burn sequencer: sums stack mass, then loads, burns, separates and coasts each stage in turn.
// Optional burn watchdog (abort on overlong burn) is built when STAGE_SEQ_WATCHDOG_EN is defined.
module stage_sequencer #(
  parameter int N            = 64,
  parameter int NUM_STAGES   = 4,
  parameter int COAST_CYCLES = 3,
  parameter int WD_SHIFT     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  launch,
  input  logic                  abort,
  input  logic                  ignition_end,
  input  logic [N-1:0]          payload,
  input  logic [NUM_STAGES*N-1:0] isp_tbl,
  input  logic [NUM_STAGES*N-1:0] prop_tbl,
  input  logic [NUM_STAGES*N-1:0] burn_tbl,
  input  logic [NUM_STAGES*N-1:0] dry_tbl,
  output logic [3:0]            stage_idx,
  output logic                  stage_start,
  output logic [N-1:0]          specific_impulse,
  output logic [N-1:0]          initial_weight,
  output logic [N-1:0]          propellant_weight,
  output logic [N-1:0]          burntime,
  output logic                  burning,
  output logic                  coasting,
  output logic                  sep_pulse,
  output logic                  mission_done,
  output logic                  aborted,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SUM = 3'd1, S_LOAD = 3'd2, S_BURN = 3'd3,
    S_SEP = 3'd4, S_COAST = 3'd5, S_DONE = 3'd6, S_ABORT = 3'd7
  } state_t;

  if (NUM_STAGES < 2 || NUM_STAGES > 16 || WD_SHIFT < 0 || WD_SHIFT >= N) begin : g_bad_params
    $error("stage_sequencer: parameter out of range");
  end

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_acc, w_acc_nxt;
  logic [31:0]   r_cnt, w_cnt_nxt;
  logic [3:0]    r_stage, w_stage_nxt;
  logic [N-1:0]  r_isp, r_iw, r_prop, r_burntime, r_dry;

  // Tables padded to 16 entries so a 4-bit index is always in range.
  logic [N-1:0]  w_isp [16];
  logic [N-1:0]  w_prop[16];
  logic [N-1:0]  w_burn[16];
  logic [N-1:0]  w_dry [16];

  for (genvar k = 0; k < 16; k++) begin : g_tbl
    if (k < NUM_STAGES) begin : g_used
      assign w_isp[k]  = isp_tbl [k*N +: N];
      assign w_prop[k] = prop_tbl[k*N +: N];
      assign w_burn[k] = burn_tbl[k*N +: N];
      assign w_dry[k]  = dry_tbl [k*N +: N];
    end else begin : g_pad
      assign w_isp[k]  = '0;
      assign w_prop[k] = '0;
      assign w_burn[k] = '0;
      assign w_dry[k]  = '0;
    end
  end

`ifdef STAGE_SEQ_WATCHDOG_EN
  // Counts from the LOAD cycle, so BURN cycle j sees j here.
  logic [N-1:0] r_wd;
  logic         w_wd_over;
  assign w_wd_over = (r_wd + 1'b1) > (r_burntime << WD_SHIFT);

  always_ff @(posedge clk) begin
    if (reset)                                   r_wd <= '0;
    else if (w_state_nxt == S_LOAD)              r_wd <= '0;
    else if (r_state == S_LOAD || r_state == S_BURN) r_wd <= r_wd + 1'b1;
  end
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_stage_nxt  = r_stage;
    stage_start  = 1'b0;
    burning      = 1'b0;
    coasting     = 1'b0;
    sep_pulse    = 1'b0;
    mission_done = 1'b0;
    aborted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (launch) begin
          w_state_nxt = S_SUM;
          w_acc_nxt   = payload;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
        end
      end
      S_SUM: begin
        w_acc_nxt = r_acc + w_prop[r_cnt[3:0]] + w_dry[r_cnt[3:0]];
        if (r_cnt[3:0] == 4'(NUM_STAGES - 1)) begin
          w_state_nxt = S_LOAD;
          w_stage_nxt = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_LOAD: begin
        stage_start = 1'b1;
        w_state_nxt = S_BURN;
        w_cnt_nxt   = '0;
      end
      S_BURN: begin
        burning = 1'b1;
        if (ignition_end) begin
          w_acc_nxt = r_acc - (r_prop + r_dry);
          w_cnt_nxt = '0;
          if (r_stage == 4'(NUM_STAGES - 1)) begin
            w_state_nxt = S_DONE;
          end else if (r_dry != '0) begin
            w_state_nxt = S_SEP;
          end else if (COAST_CYCLES == 0) begin
            w_state_nxt = S_LOAD;
            w_stage_nxt = r_stage + 4'd1;
          end else begin
            w_state_nxt = S_COAST;
          end
        end
`ifdef STAGE_SEQ_WATCHDOG_EN
        else if (w_wd_over) begin
          w_state_nxt = S_ABORT;
        end
`endif
      end
      S_SEP: begin
        sep_pulse = 1'b1;
        w_cnt_nxt = '0;
        if (COAST_CYCLES == 0) begin
          w_state_nxt = S_LOAD;
          w_stage_nxt = r_stage + 4'd1;
        end else begin
          w_state_nxt = S_COAST;
        end
      end
      S_COAST: begin
        coasting = 1'b1;
        if (r_cnt == 32'(COAST_CYCLES - 1)) begin
          w_state_nxt = S_LOAD;
          w_stage_nxt = r_stage + 4'd1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_DONE:  mission_done = 1'b1;
      S_ABORT: aborted      = 1'b1;
      default: w_state_nxt  = S_IDLE;
    endcase

    // Abort overrides any same-cycle progress, including the mass update.
    if (abort && r_state != S_IDLE && r_state != S_DONE && r_state != S_ABORT) begin
      w_state_nxt = S_ABORT;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_stage_nxt = r_stage;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_isp      <= '0;
      r_iw       <= '0;
      r_prop     <= '0;
      r_burntime <= {{(N-1){1'b0}}, 1'b1};
      r_dry      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      // Stage outputs are captured on the edge into LOAD so they are valid alongside stage_start.
      if (w_state_nxt == S_LOAD) begin
        r_isp      <= w_isp [w_stage_nxt];
        r_iw       <= w_acc_nxt;
        r_prop     <= w_prop[w_stage_nxt];
        r_burntime <= w_burn[w_stage_nxt];
        r_dry      <= w_dry [w_stage_nxt];
      end
    end
  end

  assign stage_idx         = r_stage;
  assign specific_impulse  = r_isp;
  assign initial_weight    = r_iw;
  assign propellant_weight = r_prop;
  assign burntime          = r_burntime;
  assign state             = r_state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: nominal four-stage mission, latency, abort, reset and table-sampling cases.
module tb_stage_sequencer;
  localparam int N  = 64;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            reset, launch, abort, ignition_end;
  logic [N-1:0]    payload;
  logic [NS*N-1:0] isp_tbl, prop_tbl, burn_tbl, dry_tbl;
  logic [3:0]      stage_idx;
  logic            stage_start, burning, coasting, sep_pulse, mission_done, aborted;
  logic [N-1:0]    specific_impulse, initial_weight, propellant_weight, burntime;
  logic [2:0]      state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_iw   [4];
  logic [63:0] exp_isp  [4];
  logic [63:0] exp_prop [4];
  logic [63:0] exp_burn [4];
  int          exp_gap  [3];
  int          exp_sep  [3];

  stage_sequencer #(.N(N), .NUM_STAGES(NS), .COAST_CYCLES(3), .WD_SHIFT(20)) dut (
    .clk(clk), .reset(reset), .launch(launch), .abort(abort), .ignition_end(ignition_end),
    .payload(payload), .isp_tbl(isp_tbl), .prop_tbl(prop_tbl), .burn_tbl(burn_tbl), .dry_tbl(dry_tbl),
    .stage_idx(stage_idx), .stage_start(stage_start), .specific_impulse(specific_impulse),
    .initial_weight(initial_weight), .propellant_weight(propellant_weight), .burntime(burntime),
    .burning(burning), .coasting(coasting), .sep_pulse(sep_pulse), .mission_done(mission_done),
    .aborted(aborted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_tables;
    payload  = 64'd27003;
    isp_tbl  = {64'd311, 64'd421, 64'd421, 64'd300};
    prop_tbl = {64'd83864, 64'd39136, 64'd456100, 64'd2077000};
    burn_tbl = {64'd480, 64'd160, 64'd360, 64'd150};
    dry_tbl  = {64'd15200, 64'd0, 64'd40100, 64'd137000};
  endtask

  task automatic do_reset;
    reset = 1'b1; launch = 1'b0; abort = 1'b0; ignition_end = 1'b0;
    step; step;
    reset = 1'b0;
  endtask

  // Steps until stage_start is seen (bounded); reports steps taken and sep/coast cycles passed.
  task automatic wait_start(output int cyc, output int nsep, output int ncoast);
    cyc = 0; nsep = 0; ncoast = 0;
    while (cyc < 60) begin
      if (stage_start) break;
      nsep   += int'(sep_pulse);
      ncoast += int'(coasting);
      step;
      cyc++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++;
    if ({stage_start, burning, coasting, sep_pulse, mission_done, aborted} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                         {stage_start, burning, coasting, sep_pulse, mission_done, aborted});
    end
    n_checks++;
    if (burntime !== 64'd1) begin n_fail++; $display("FAIL reset_burntime: got %0d expected 1", burntime); end
    n_checks++;
    if ({specific_impulse, initial_weight, propellant_weight} !== '0 || stage_idx !== 4'd0) begin
      n_fail++; $display("FAIL reset_params: got isp=%0d iw=%0d prop=%0d idx=%0d expected all 0",
                         specific_impulse, initial_weight, propellant_weight, stage_idx);
    end
  endtask

  task automatic run_mission(input int run);
    int c, ns, nc;
    launch = 1'b1; step; launch = 1'b0;
    for (int k = 0; k < NS; k++) begin
      wait_start(c, ns, nc);
      if (k == 0) begin
        n_checks++;
        if (c + 1 !== 5) begin n_fail++; $display("FAIL run%0d_launch_latency: got %0d expected 5", run, c + 1); end
      end else begin
        n_checks++;
        if (c + 1 !== exp_gap[k-1]) begin
          n_fail++; $display("FAIL run%0d_gap_stage%0d: got %0d expected %0d", run, k, c + 1, exp_gap[k-1]);
        end
        n_checks++;
        if (ns !== exp_sep[k-1] || nc !== 3) begin
          n_fail++; $display("FAIL run%0d_sep_coast_stage%0d: got sep=%0d coast=%0d expected sep=%0d coast=3",
                             run, k, ns, nc, exp_sep[k-1]);
        end
      end
      n_checks++;
      if (initial_weight !== exp_iw[k] || stage_idx !== 4'(k)) begin
        n_fail++; $display("FAIL run%0d_iw_stage%0d: got iw=%0d idx=%0d expected iw=%0d idx=%0d",
                           run, k, initial_weight, stage_idx, exp_iw[k], k);
      end
      n_checks++;
      if (specific_impulse !== exp_isp[k] || propellant_weight !== exp_prop[k] || burntime !== exp_burn[k]) begin
        n_fail++; $display("FAIL run%0d_params_stage%0d: got isp=%0d prop=%0d burn=%0d expected %0d %0d %0d",
                           run, k, specific_impulse, propellant_weight, burntime,
                           exp_isp[k], exp_prop[k], exp_burn[k]);
      end
      step;
      n_checks++;
      if (burning !== 1'b1 || stage_start !== 1'b0 || state !== 3'd3) begin
        n_fail++; $display("FAIL run%0d_burn_stage%0d: got burning=%b start=%b state=%0d expected 1 0 3",
                           run, k, burning, stage_start, state);
      end
      launch = 1'b1; step; launch = 1'b0;
      step;
      ignition_end = 1'b1; step; ignition_end = 1'b0;
    end
    n_checks++;
    if (mission_done !== 1'b1 || state !== 3'd6 || burning !== 1'b0) begin
      n_fail++; $display("FAIL run%0d_done: got done=%b state=%0d burning=%b expected 1 6 0",
                         run, mission_done, state, burning);
    end
  endtask

  task automatic test_nominal;
    do_reset;
    abort = 1'b1; step; abort = 1'b0;
    n_checks++;
    if (state !== 3'd0 || aborted !== 1'b0) begin
      n_fail++; $display("FAIL idle_abort_ignored: got state=%0d aborted=%b expected 0 0", state, aborted);
    end
    run_mission(1);
    abort = 1'b1; step; abort = 1'b0; step;
    n_checks++;
    if (state !== 3'd6 || mission_done !== 1'b1 || aborted !== 1'b0) begin
      n_fail++; $display("FAIL done_abort_ignored: got state=%0d done=%b aborted=%b expected 6 1 0",
                         state, mission_done, aborted);
    end
  endtask

  task automatic test_abort_burn;
    int c, ns, nc;
    do_reset;
    launch = 1'b1; step; launch = 1'b0;
    wait_start(c, ns, nc);
    step;
    ignition_end = 1'b1; step; ignition_end = 1'b0;
    wait_start(c, ns, nc);
    step;
    abort = 1'b1; step; abort = 1'b0;
    n_checks++;
    if (aborted !== 1'b1 || burning !== 1'b0 || state !== 3'd7) begin
      n_fail++; $display("FAIL abort_burn: got aborted=%b burning=%b state=%0d expected 1 0 7",
                         aborted, burning, state);
    end
    ignition_end = 1'b1; launch = 1'b1; step; ignition_end = 1'b0; launch = 1'b0; step;
    n_checks++;
    if (state !== 3'd7 || stage_idx !== 4'd1 || initial_weight !== 64'd661403 || stage_start !== 1'b0) begin
      n_fail++; $display("FAIL abort_sticky: got state=%0d idx=%0d iw=%0d start=%b expected 7 1 661403 0",
                         state, stage_idx, initial_weight, stage_start);
    end
  endtask

  task automatic test_abort_with_ignition;
    int c, ns, nc;
    do_reset;
    launch = 1'b1; step; launch = 1'b0;
    wait_start(c, ns, nc);
    step;
    abort = 1'b1; ignition_end = 1'b1; step; abort = 1'b0; ignition_end = 1'b0;
    n_checks++;
    if (state !== 3'd7 || stage_idx !== 4'd0 || initial_weight !== 64'd2875403 || sep_pulse !== 1'b0) begin
      n_fail++; $display("FAIL abort_and_ign: got state=%0d idx=%0d iw=%0d sep=%b expected 7 0 2875403 0",
                         state, stage_idx, initial_weight, sep_pulse);
    end
  endtask

  task automatic test_reset_in_coast;
    int c, ns, nc;
    do_reset;
    launch = 1'b1; step; launch = 1'b0;
    wait_start(c, ns, nc);
    step;
    ignition_end = 1'b1; step; ignition_end = 1'b0;
    step;
    n_checks++;
    if (coasting !== 1'b1 || state !== 3'd5) begin
      n_fail++; $display("FAIL coast_reached: got coasting=%b state=%0d expected 1 5", coasting, state);
    end
    reset = 1'b1; abort = 1'b1; ignition_end = 1'b1; launch = 1'b1;
    step;
    reset = 1'b0; abort = 1'b0; ignition_end = 1'b0; launch = 1'b0;
    n_checks++;
    if (state !== 3'd0 || {stage_start, burning, coasting, sep_pulse, mission_done, aborted} !== 6'b0 ||
        burntime !== 64'd1 || initial_weight !== 64'd0 || stage_idx !== 4'd0) begin
      n_fail++; $display("FAIL coast_reset: got state=%0d flags=%b burn=%0d iw=%0d idx=%0d expected 0 000000 1 0 0",
                         state, {stage_start, burning, coasting, sep_pulse, mission_done, aborted},
                         burntime, initial_weight, stage_idx);
    end
    run_mission(2);
  endtask

  task automatic test_table_mid_burn;
    int c, ns, nc;
    do_reset;
    launch = 1'b1; step; launch = 1'b0;
    wait_start(c, ns, nc);
    step;
    prop_tbl[63:0]    = 64'd0;
    burn_tbl[127:64]  = 64'd999;
    step;
    ignition_end = 1'b1; step; ignition_end = 1'b0;
    wait_start(c, ns, nc);
    n_checks++;
    if (initial_weight !== 64'd661403 || burntime !== 64'd999) begin
      n_fail++; $display("FAIL table_mid_burn: got iw=%0d burn=%0d expected 661403 999", initial_weight, burntime);
    end
    load_tables;
  endtask

  task automatic test_no_watchdog;
    int c, ns, nc;
    do_reset;
    launch = 1'b1; step; launch = 1'b0;
    wait_start(c, ns, nc);
    step;
    repeat (1000) step;
    n_checks++;
    if (state !== 3'd3 || burning !== 1'b1 || aborted !== 1'b0) begin
      n_fail++; $display("FAIL long_burn: got state=%0d burning=%b aborted=%b expected 3 1 0",
                         state, burning, aborted);
    end
  endtask

  initial begin
    exp_iw   = '{64'd2875403, 64'd661403, 64'd165203, 64'd126067};
    exp_isp  = '{64'd300, 64'd421, 64'd421, 64'd311};
    exp_prop = '{64'd2077000, 64'd456100, 64'd39136, 64'd83864};
    exp_burn = '{64'd150, 64'd360, 64'd160, 64'd480};
    exp_gap  = '{5, 5, 4};
    exp_sep  = '{1, 1, 0};
    reset = 1'b1; launch = 1'b0; abort = 1'b0; ignition_end = 1'b0;
    load_tables;
    test_reset;
    test_nominal;
    test_abort_burn;
    test_abort_with_ignition;
    test_reset_in_coast;
    test_table_mid_burn;
    test_no_watchdog;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
